// File: rtl/vga_v_timing.sv
// Vertical line counter and registered sync/video decoder for 640x480@60 VGA.
// Locks to the horizontal end-of-line pulse and drops lock on a malformed stream.
module vga_v_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] h_count,
    input  logic       trig_v,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start,
    output logic       sync_err
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS_W   = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS_W   = 10'(V_VISIBLE);
    localparam logic [9:0]  HS_START  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  VS_START  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } state_t;

    state_t     state, state_next;
    logic       err, lock;
    logic [9:0] v_next, v_count_next;
    logic       hsync_next, vsync_next, video_on_next, frame_start_next;
    logic [9:0] pixel_x_next, pixel_y_next;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        err              = 1'b0;
        lock             = 1'b0;
        v_next           = v_count;
        state_next       = state;
        v_count_next     = v_count;
        hsync_next       = 1'b1;
        vsync_next       = 1'b1;
        video_on_next    = 1'b0;
        pixel_x_next     = '0;
        pixel_y_next     = '0;
        frame_start_next = 1'b0;

        err = (trig_v && h_count != '0)
           || ({1'b0, h_count} >= H_TOTAL_W)
           || (state == LOCKED && h_count == '0 && !trig_v);
        lock = (state == UNLOCKED) && trig_v && (h_count == '0);

        if (lock)
            v_next = '0;
        else if (state == LOCKED && trig_v)
            v_next = (v_count == V_LAST) ? '0 : v_count + 10'd1;

        // An error wins over locking and leaves the line counter untouched.
        if (err) begin
            state_next = UNLOCKED;
        end else begin
            if (lock)
                state_next = LOCKED;
            v_count_next = v_next;
        end

        if (!err && state_next == LOCKED) begin
            hsync_next       = !(h_count >= HS_START && h_count < HS_END);
            vsync_next       = !(v_next >= VS_START && v_next < VS_END);
            video_on_next    = (h_count < H_VIS_W) && (v_next < V_VIS_W);
            pixel_x_next     = video_on_next ? h_count : '0;
            pixel_y_next     = video_on_next ? v_next  : '0;
            frame_start_next = trig_v && (v_next == '0);
        end
    end

    // NOTE: registers use non-blocking assignment so all state updates on an
    // edge see the pre-edge values, matching real flip-flop behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= UNLOCKED;
            v_count     <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_next;
            v_count     <= v_count_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            video_on    <= video_on_next;
            pixel_x     <= pixel_x_next;
            pixel_y     <= pixel_y_next;
            frame_start <= frame_start_next;
            sync_err    <= sync_err | err;
        end
    end

endmodule

// File: tb/tb_vga_v_timing.sv
// Directed bench for vga_v_timing: lock-up, frame decode, wrap, error recovery, async reset.
// Lines are mostly compressed to a few representative h samples to keep runs short.
module tb_vga_v_timing;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] h_count;
    logic       trig_v;
    logic [9:0] v_count;
    logic       hsync, vsync, video_on;
    logic [9:0] pixel_x, pixel_y;
    logic       frame_start, sync_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Representative samples of one line; index 0 carries the end-of-line pulse.
    int samp [9] = '{0, 1, 639, 640, 655, 656, 751, 752, 799};

    localparam logic [34:0] RESET_VEC = {10'd0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
    localparam logic [23:0] IDLE_VEC  = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0};

    vga_v_timing dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_count     (h_count),
        .trig_v      (trig_v),
        .v_count     (v_count),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    // Drive one input sample, clock it in, and land 1 ns after the edge.
    task automatic step(input int h, input logic t);
        h_count = 10'(h);
        trig_v  = t;
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(0, 1'b0);
        step(0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        h_count = '0;
        trig_v  = 1'b0;
        #12;
        n_checks++;
        if ({v_count, hsync, vsync, video_on, pixel_x, pixel_y, frame_start, sync_err} !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h",
                     {v_count, hsync, vsync, video_on, pixel_x, pixel_y, frame_start, sync_err}, RESET_VEC);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_power_up();
        int hs_cnt, hs_first, hs_last, vid_cnt;
        hs_cnt = 0; hs_first = -1; hs_last = -1; vid_cnt = 0;
        // Partial first line without trig_v: must stay idle.
        for (int h = 0; h < 800; h++) begin
            step(h, 1'b0);
            n_checks++;
            if ({hsync, vsync, video_on, pixel_x, pixel_y, frame_start} !== IDLE_VEC) begin
                n_fail++;
                $display("FAIL idle_before_lock h=%0d: got %h expected %h", h,
                         {hsync, vsync, video_on, pixel_x, pixel_y, frame_start}, IDLE_VEC);
            end
        end
        step(0, 1'b1);
        n_checks++;
        if ({frame_start, v_count, sync_err} !== {1'b1, 10'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL lock_frame_start: got fs=%0d v=%0d err=%0d expected fs=1 v=0 err=0",
                     frame_start, v_count, sync_err);
        end
        for (int h = 1; h < 800; h++) begin
            step(h, 1'b0);
            if (h == 1) begin
                n_checks++;
                if (frame_start !== 1'b0) begin
                    n_fail++;
                    $display("FAIL frame_start_one_cycle: got %0d expected 0", frame_start);
                end
            end
        end
        // Line 1 in full: the first fully locked line.
        for (int h = 0; h < 800; h++) begin
            step(h, h == 0);
            if (h == 0) begin
                n_checks++;
                if ({v_count, pixel_y, video_on, frame_start} !== {10'd1, 10'd1, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL line1_start: got v=%0d py=%0d vid=%0d fs=%0d expected v=1 py=1 vid=1 fs=0",
                             v_count, pixel_y, video_on, frame_start);
                end
            end
            if (!hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = h;
                hs_last = h;
            end
            if (video_on) vid_cnt++;
        end
        n_checks++;
        if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
            n_fail++;
            $display("FAIL hsync_window: got count=%0d first=%0d last=%0d expected count=96 first=656 last=751",
                     hs_cnt, hs_first, hs_last);
        end
        n_checks++;
        if (vid_cnt != 640) begin
            n_fail++;
            $display("FAIL video_per_line: got %0d expected 640", vid_cnt);
        end
    endtask

    task automatic test_frames();
        int vid_cnt, hs_cnt, vs_lines, vs_first, fs_cnt, fs_cycle;
        vid_cnt = 0; hs_cnt = 0; vs_lines = 0; vs_first = -1; fs_cnt = 0; fs_cycle = 0;
        for (int l = 2; l < 525; l++)
            for (int i = 0; i < 9; i++)
                step(samp[i], i == 0);
        n_checks++;
        if (v_count !== 10'd524) begin
            n_fail++;
            $display("FAIL last_line: got %0d expected 524", v_count);
        end
        for (int l = 0; l < 525; l++) begin
            for (int i = 0; i < 9; i++) begin
                step(samp[i], i == 0);
                if (i == 0) begin
                    n_checks++;
                    if (v_count !== 10'(l)) begin
                        n_fail++;
                        $display("FAIL v_count line=%0d: got %0d expected %0d", l, v_count, l);
                    end
                    if (l == 0) begin
                        fs_cycle = cycle;
                        n_checks++;
                        if (frame_start !== 1'b1) begin
                            n_fail++;
                            $display("FAIL wrap_frame_start: got %0d expected 1", frame_start);
                        end
                    end
                    if (!vsync) begin
                        vs_lines++;
                        if (vs_first < 0) vs_first = l;
                    end
                end
                if (frame_start) fs_cnt++;
                if (video_on) vid_cnt++;
                if (!hsync) hs_cnt++;
                if (l == 479 && i == 2) begin
                    n_checks++;
                    if ({pixel_x, pixel_y, video_on} !== {10'd639, 10'd479, 1'b1}) begin
                        n_fail++;
                        $display("FAIL last_visible_pixel: got x=%0d y=%0d vid=%0d expected x=639 y=479 vid=1",
                                 pixel_x, pixel_y, video_on);
                    end
                end
                if (l == 479 && i == 3) begin
                    n_checks++;
                    if ({pixel_x, pixel_y, video_on} !== {10'd0, 10'd0, 1'b0}) begin
                        n_fail++;
                        $display("FAIL first_blank_pixel: got x=%0d y=%0d vid=%0d expected x=0 y=0 vid=0",
                                 pixel_x, pixel_y, video_on);
                    end
                end
            end
        end
        step(0, 1'b1);
        n_checks++;
        if (frame_start !== 1'b1 || (cycle - fs_cycle) != 4725) begin
            n_fail++;
            $display("FAIL frame_period: got fs=%0d period=%0d expected fs=1 period=4725",
                     frame_start, cycle - fs_cycle);
        end
        n_checks++;
        if (vid_cnt != 1440) begin
            n_fail++;
            $display("FAIL video_per_frame: got %0d expected 1440", vid_cnt);
        end
        n_checks++;
        if (hs_cnt != 1050) begin
            n_fail++;
            $display("FAIL hsync_per_frame: got %0d expected 1050", hs_cnt);
        end
        n_checks++;
        if (vs_lines != 2 || vs_first != 490) begin
            n_fail++;
            $display("FAIL vsync_lines: got count=%0d first=%0d expected count=2 first=490", vs_lines, vs_first);
        end
        n_checks++;
        if (fs_cnt != 1) begin
            n_fail++;
            $display("FAIL frame_start_per_frame: got %0d expected 1", fs_cnt);
        end
    endtask

    task automatic test_err_trig();
        step(1, 1'b0);
        step(5, 1'b1);
        n_checks++;
        if (sync_err !== 1'b1 || {hsync, vsync, video_on, pixel_x, pixel_y, frame_start} !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL err_trig_mid_line: got err=%0d out=%h expected err=1 out=%h", sync_err,
                     {hsync, vsync, video_on, pixel_x, pixel_y, frame_start}, IDLE_VEC);
        end
        step(6, 1'b0);
        n_checks++;
        if ({hsync, vsync, video_on, pixel_x, pixel_y, frame_start} !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL err_trig_unlocked: got %h expected %h",
                     {hsync, vsync, video_on, pixel_x, pixel_y, frame_start}, IDLE_VEC);
        end
        step(799, 1'b0);
        step(0, 1'b1);
        n_checks++;
        if ({frame_start, v_count, sync_err} !== {1'b1, 10'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL relock: got fs=%0d v=%0d err=%0d expected fs=1 v=0 err=1",
                     frame_start, v_count, sync_err);
        end
        step(1, 1'b0);
        n_checks++;
        if ({video_on, pixel_x, sync_err} !== {1'b1, 10'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL relocked_decode: got vid=%0d x=%0d err=%0d expected vid=1 x=1 err=1",
                     video_on, pixel_x, sync_err);
        end
    endtask

    task automatic test_err_h0();
        do_reset();
        step(0, 1'b1);
        step(1, 1'b0);
        step(2, 1'b0);
        step(0, 1'b0);
        n_checks++;
        if ({sync_err, video_on, frame_start} !== {1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL err_missing_trig: got err=%0d vid=%0d fs=%0d expected err=1 vid=0 fs=0",
                     sync_err, video_on, frame_start);
        end
        step(1, 1'b0);
        n_checks++;
        if (video_on !== 1'b0) begin
            n_fail++;
            $display("FAIL err_missing_trig_unlocked: got vid=%0d expected 0", video_on);
        end
    endtask

    task automatic test_err_range();
        do_reset();
        step(0, 1'b1);
        step(1, 1'b0);
        n_checks++;
        if ({video_on, sync_err} !== {1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL range_pre_locked: got vid=%0d err=%0d expected vid=1 err=0", video_on, sync_err);
        end
        step(900, 1'b0);
        n_checks++;
        if (sync_err !== 1'b1 || {hsync, vsync, video_on, pixel_x, pixel_y, frame_start} !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL err_h_range: got err=%0d out=%h expected err=1 out=%h", sync_err,
                     {hsync, vsync, video_on, pixel_x, pixel_y, frame_start}, IDLE_VEC);
        end
        step(2, 1'b0);
        n_checks++;
        if (video_on !== 1'b0) begin
            n_fail++;
            $display("FAIL err_h_range_unlocked: got vid=%0d expected 0", video_on);
        end
    endtask

    task automatic test_err_priority();
        do_reset();
        step(3, 1'b1);
        n_checks++;
        if ({sync_err, frame_start} !== {1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL err_over_lock: got err=%0d fs=%0d expected err=1 fs=0", sync_err, frame_start);
        end
        step(4, 1'b0);
        n_checks++;
        if ({video_on, pixel_x} !== {1'b0, 10'd0}) begin
            n_fail++;
            $display("FAIL err_over_lock_unlocked: got vid=%0d x=%0d expected vid=0 x=0", video_on, pixel_x);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(0, 1'b1);
        step(1, 1'b0);
        for (int l = 1; l <= 300; l++) begin
            step(0, 1'b1);
            step(1, 1'b0);
        end
        step(400, 1'b0);
        n_checks++;
        if ({v_count, video_on, pixel_x, pixel_y} !== {10'd300, 1'b1, 10'd400, 10'd300}) begin
            n_fail++;
            $display("FAIL pre_reset_state: got v=%0d vid=%0d x=%0d y=%0d expected v=300 vid=1 x=400 y=300",
                     v_count, video_on, pixel_x, pixel_y);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({v_count, hsync, vsync, video_on, pixel_x, pixel_y, frame_start, sync_err} !== RESET_VEC) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h",
                     {v_count, hsync, vsync, video_on, pixel_x, pixel_y, frame_start, sync_err}, RESET_VEC);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(401, 1'b0);
        step(402, 1'b0);
        step(799, 1'b0);
        n_checks++;
        if ({v_count, sync_err} !== {10'd0, 1'b0}
            || {hsync, vsync, video_on, pixel_x, pixel_y, frame_start} !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL post_reset_wait: got v=%0d err=%0d out=%h expected v=0 err=0 out=%h", v_count,
                     sync_err, {hsync, vsync, video_on, pixel_x, pixel_y, frame_start}, IDLE_VEC);
        end
        step(0, 1'b1);
        n_checks++;
        if ({frame_start, v_count} !== {1'b1, 10'd0}) begin
            n_fail++;
            $display("FAIL post_reset_lock: got fs=%0d v=%0d expected fs=1 v=0", frame_start, v_count);
        end
        step(1, 1'b0);
        n_checks++;
        if ({frame_start, video_on} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset_run: got fs=%0d vid=%0d expected fs=0 vid=1", frame_start, video_on);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_frames();
        test_err_trig();
        test_err_h0();
        test_err_range();
        test_err_priority();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
